// File: rtl/vga_pkg.sv
// Shared VGA timing constants, cursor geometry and mouse FSM types.
package vga_pkg;

   localparam int H_ACTIVE = 800;
   localparam int V_ACTIVE = 600;
   localparam int CUR_W = 16;
   localparam int CUR_H = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      COMMIT  = 2'd2
   } mouse_fsm_t;

   typedef struct packed {
      logic [11:0] x;
      logic [11:0] y;
   } mouse_xy_t;

endpackage

// File: rtl/mouse_frame_ctl_if.sv
// Mouse sample, committed position and click handshake bundle.
interface mouse_frame_ctl_if;

   logic [11:0] xpos_raw;
   logic [11:0] ypos_raw;
   logic        left_raw;
   logic        new_event;
   logic        vblnk;
   logic [11:0] xpos;
   logic [11:0] ypos;
   logic        click_valid;
   logic [11:0] click_x;
   logic [11:0] click_y;
   logic        click_ready;
   logic        click_ovf;

   modport master (
      output xpos_raw, ypos_raw, left_raw, new_event, vblnk,
      output click_ready,
      input  xpos, ypos, click_valid, click_x, click_y, click_ovf
   );

   modport slave (
      input  xpos_raw, ypos_raw, left_raw, new_event, vblnk,
      input  click_ready,
      output xpos, ypos, click_valid, click_x, click_y, click_ovf
   );

endinterface

// File: rtl/mouse_clamp.sv
// Clamps a raw mouse sample to the visible area minus the cursor size.
// Clamping is enabled by defining MOUSE_FRAME_CTL_CLAMP_EN.
module mouse_clamp #(
   parameter int H_ACTIVE = 800,
   parameter int V_ACTIVE = 600,
   parameter int CUR_W    = 16,
   parameter int CUR_H    = 16
) (
   input  logic [11:0] x_raw,
   input  logic [11:0] y_raw,
   output logic [11:0] xc,
   output logic [11:0] yc
);

`ifdef MOUSE_FRAME_CTL_CLAMP_EN
   localparam logic [11:0] XMAX = 12'(H_ACTIVE - CUR_W);
   localparam logic [11:0] YMAX = 12'(V_ACTIVE - CUR_H);
`else
   // An all-ones bound turns the compare into a pass-through.
   localparam logic [11:0] XMAX = 12'hfff | 12'(H_ACTIVE - CUR_W);
   localparam logic [11:0] YMAX = 12'hfff | 12'(V_ACTIVE - CUR_H);
`endif

   assign xc = (x_raw > XMAX) ? XMAX : x_raw;
   assign yc = (y_raw > YMAX) ? YMAX : y_raw;

endmodule

// File: rtl/mouse_frame_ctl.sv
// Commits mouse position at vblank start and emits left-click events.
// Optional clamping: MOUSE_FRAME_CTL_CLAMP_EN (evaluated in mouse_clamp).
module mouse_frame_ctl
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
   parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
   parameter int CUR_W    = vga_pkg::CUR_W,
   parameter int CUR_H    = vga_pkg::CUR_H
) (
   input logic             clk40MHz,
   input logic             rst,
   mouse_frame_ctl_if.slave bus
);

   logic [11:0] xc, yc;
   mouse_xy_t   samp;

   mouse_clamp #(
      .H_ACTIVE (H_ACTIVE),
      .V_ACTIVE (V_ACTIVE),
      .CUR_W    (CUR_W),
      .CUR_H    (CUR_H)
   ) u_clamp (
      .x_raw (bus.xpos_raw),
      .y_raw (bus.ypos_raw),
      .xc    (xc),
      .yc    (yc)
   );

   mouse_fsm_t state_q, state_d;
   mouse_xy_t  pend_q, pend_d;
   mouse_xy_t  pos_q, pos_d;
   mouse_xy_t  cxy_q, cxy_d;
   logic       vblnk_q, vblnk_d;
   logic       left_q, left_d;
   logic       cval_q, cval_d;
   logic       ovf_q, ovf_d;
   logic       vb_rise, press, hs;

   always_comb begin
      samp    = '{x: xc, y: yc};
      vb_rise = bus.vblnk & ~vblnk_q;
      press   = bus.new_event & bus.left_raw & ~left_q;
      hs      = cval_q & bus.click_ready;
      vblnk_d = bus.vblnk;
      left_d  = bus.new_event ? bus.left_raw : left_q;
      state_d = state_q;
      pend_d  = pend_q;
      pos_d   = pos_q;
      // A sample arriving with vb_rise lands in pend and is committed next.
      unique case (state_q)
         IDLE: begin
            if (bus.new_event) begin
               pend_d  = samp;
               state_d = PENDING;
            end
         end
         PENDING: begin
            if (bus.new_event) pend_d = samp;
            if (vb_rise) state_d = COMMIT;
         end
         COMMIT: begin
            pos_d   = pend_q;
            state_d = bus.new_event ? PENDING : IDLE;
            if (bus.new_event) pend_d = samp;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cval_d = cval_q;
      cxy_d  = cxy_q;
      ovf_d  = ovf_q;
      if (hs) begin
         cval_d = 1'b0;
         ovf_d  = 1'b0;
      end
      if (press) begin
         if (!cval_q || hs) begin
            cval_d = 1'b1;
            cxy_d  = samp;
         end else begin
            ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk40MHz) begin
      if (rst) begin
         state_q <= IDLE;
         pend_q  <= '0;
         pos_q   <= '0;
         cxy_q   <= '0;
         vblnk_q <= 1'b0;
         left_q  <= 1'b0;
         cval_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         pos_q   <= pos_d;
         cxy_q   <= cxy_d;
         vblnk_q <= vblnk_d;
         left_q  <= left_d;
         cval_q  <= cval_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.xpos        = pos_q.x;
   assign bus.ypos        = pos_q.y;
   assign bus.click_valid = cval_q;
   assign bus.click_x     = cxy_q.x;
   assign bus.click_y     = cxy_q.y;
   assign bus.click_ovf   = ovf_q;

endmodule

// File: tb/tb_mouse_frame_ctl.sv
// Scoreboard bench for mouse_frame_ctl (commit timing, clamp, clicks).
`timescale 1ns/1ps
module tb_mouse_frame_ctl;

   typedef struct {
      logic [11:0] x;
      logic [11:0] y;
   } xy_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   errors = 0;
   xy_t  pos_q[$];
   xy_t  clk_q[$];
   xy_t  e;
   xy_t  last;

   always #5 clk = ~clk;

   mouse_frame_ctl_if mif();

   mouse_frame_ctl dut (
      .clk40MHz (clk),
      .rst      (rst),
      .bus      (mif.slave)
   );

   function automatic xy_t clampxy(input int x, input int y);
      xy_t r;
      r.x = 12'(x);
      r.y = 12'(y);
`ifdef MOUSE_FRAME_CTL_CLAMP_EN
      if (x > 784) r.x = 12'd784;
      if (y > 584) r.y = 12'd584;
`endif
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int x, input int y, input logic l);
      mif.xpos_raw  = 12'(x);
      mif.ypos_raw  = 12'(y);
      mif.left_raw  = l;
      mif.new_event = 1'b1;
      step();
      mif.new_event = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         mif.new_event = 1'(i % 2 == 0);
         mif.left_raw  = 1'b1;
         mif.vblnk     = 1'(i % 2);
         mif.xpos_raw  = 12'(123 + i);
         mif.ypos_raw  = 12'(456 + i);
         step();
      end
      vectors++;
      if ({mif.xpos, mif.ypos} !== 24'd0) begin
         errors++;
         $display("FAIL reset_pos got %0d,%0d want 0,0", mif.xpos, mif.ypos);
      end
      vectors++;
      if ({mif.click_valid, mif.click_ovf} !== 2'b00) begin
         errors++;
         $display("FAIL reset_click got v=%b o=%b want 0,0",
                  mif.click_valid, mif.click_ovf);
      end
      rst = 1'b0;
      mif.new_event = 1'b0;
      mif.left_raw  = 1'b0;
      mif.vblnk     = 1'b0;
      step();
      step();
      vectors++;
      if ({mif.xpos, mif.ypos, mif.click_x, mif.click_y} !== 48'd0) begin
         errors++;
         $display("FAIL post_reset got %0d,%0d c=%0d,%0d want zeros",
                  mif.xpos, mif.ypos, mif.click_x, mif.click_y);
      end
      last = '{x: 12'd0, y: 12'd0};
   endtask

   task automatic test_commit();
      send(100, 200, 1'b0);
      pos_q.push_back(clampxy(100, 200));
      for (int i = 0; i < 3; i++) step();
      vectors++;
      if (mif.xpos !== last.x || mif.ypos !== last.y) begin
         errors++;
         $display("FAIL commit_early got %0d,%0d want %0d,%0d",
                  mif.xpos, mif.ypos, last.x, last.y);
      end
      mif.vblnk = 1'b1;
      step();
      vectors++;
      if (mif.xpos !== last.x || mif.ypos !== last.y) begin
         errors++;
         $display("FAIL commit_edgeN got %0d,%0d want %0d,%0d",
                  mif.xpos, mif.ypos, last.x, last.y);
      end
      step();
      e = pos_q.pop_front();
      vectors++;
      if (mif.xpos !== e.x || mif.ypos !== e.y) begin
         errors++;
         $display("FAIL commit_edgeN1 got %0d,%0d want %0d,%0d",
                  mif.xpos, mif.ypos, e.x, e.y);
      end
      last = e;
      step();
      mif.vblnk = 1'b0;
      for (int i = 0; i < 4; i++) step();
      vectors++;
      if (mif.xpos !== last.x || mif.ypos !== last.y) begin
         errors++;
         $display("FAIL commit_hold got %0d,%0d want %0d,%0d",
                  mif.xpos, mif.ypos, last.x, last.y);
      end
   endtask

   task automatic test_bypass();
      send(10, 10, 1'b0);
      send(20, 30, 1'b0);
      mif.vblnk = 1'b1;
      send(50, 60, 1'b0);
      pos_q.push_back(clampxy(50, 60));
      vectors++;
      if (mif.xpos !== last.x || mif.ypos !== last.y) begin
         errors++;
         $display("FAIL bypass_edgeN got %0d,%0d want %0d,%0d",
                  mif.xpos, mif.ypos, last.x, last.y);
      end
      step();
      e = pos_q.pop_front();
      vectors++;
      if (mif.xpos !== e.x || mif.ypos !== e.y) begin
         errors++;
         $display("FAIL bypass_commit got %0d,%0d want %0d,%0d",
                  mif.xpos, mif.ypos, e.x, e.y);
      end
      last = e;
      mif.vblnk = 1'b0;
      step();
      step();
   endtask

   task automatic test_clamp();
      send(900, 700, 1'b0);
      pos_q.push_back(clampxy(900, 700));
      mif.vblnk = 1'b1;
      step();
      step();
      e = pos_q.pop_front();
      vectors++;
      if (mif.xpos !== e.x || mif.ypos !== e.y) begin
         errors++;
         $display("FAIL clamp got %0d,%0d want %0d,%0d",
                  mif.xpos, mif.ypos, e.x, e.y);
      end
      last = e;
      mif.vblnk = 1'b0;
      step();
      step();
   endtask

   task automatic test_idle_vb();
      mif.vblnk = 1'b1;
      for (int i = 0; i < 3; i++) step();
      mif.vblnk = 1'b0;
      step();
      vectors++;
      if (mif.xpos !== last.x || mif.ypos !== last.y) begin
         errors++;
         $display("FAIL idle_vb got %0d,%0d want %0d,%0d",
                  mif.xpos, mif.ypos, last.x, last.y);
      end
   endtask

   task automatic test_reset_pending();
      send(77, 88, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      mif.vblnk = 1'b1;
      step();
      step();
      step();
      vectors++;
      if ({mif.xpos, mif.ypos} !== 24'd0) begin
         errors++;
         $display("FAIL reset_pending got %0d,%0d want 0,0",
                  mif.xpos, mif.ypos);
      end
      mif.vblnk = 1'b0;
      step();
   endtask

   task automatic test_click_ovf();
      mif.click_ready = 1'b0;
      send(300, 400, 1'b1);
      clk_q.push_back(clampxy(300, 400));
      send(7, 7, 1'b0);
      send(5, 5, 1'b1);
      vectors++;
      if ({mif.click_valid, mif.click_ovf} !== 2'b11 ||
          mif.click_x !== 12'd300 || mif.click_y !== 12'd400) begin
         errors++;
         $display("FAIL click_ovf got v=%b o=%b %0d,%0d want 1,1 300,400",
                  mif.click_valid, mif.click_ovf, mif.click_x, mif.click_y);
      end
      mif.click_ready = 1'b1;
      e = clk_q.pop_front();
      vectors++;
      if (mif.click_x !== e.x || mif.click_y !== e.y) begin
         errors++;
         $display("FAIL click_accept got %0d,%0d want %0d,%0d",
                  mif.click_x, mif.click_y, e.x, e.y);
      end
      step();
      mif.click_ready = 1'b0;
      vectors++;
      if ({mif.click_valid, mif.click_ovf} !== 2'b00) begin
         errors++;
         $display("FAIL click_clear got v=%b o=%b want 0,0",
                  mif.click_valid, mif.click_ovf);
      end
   endtask

   task automatic test_held();
      int n;
      n = 0;
      send(1, 1, 1'b0);
      send(11, 12, 1'b1);
      clk_q.push_back(clampxy(11, 12));
      send(13, 14, 1'b1);
      send(15, 16, 1'b1);
      vectors++;
      if ({mif.click_valid, mif.click_ovf} !== 2'b10) begin
         errors++;
         $display("FAIL held_state got v=%b o=%b want 1,0",
                  mif.click_valid, mif.click_ovf);
      end
      mif.click_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (mif.click_valid === 1'b1) begin
            n++;
            if (clk_q.size() != 0) begin
               e = clk_q.pop_front();
               vectors++;
               if (mif.click_x !== e.x || mif.click_y !== e.y) begin
                  errors++;
                  $display("FAIL held_coord got %0d,%0d want %0d,%0d",
                           mif.click_x, mif.click_y, e.x, e.y);
               end
            end
         end
         step();
      end
      mif.click_ready = 1'b0;
      vectors++;
      if (n != 1) begin
         errors++;
         $display("FAIL held_count got %0d events want 1", n);
      end
   endtask

   task automatic test_back_to_back();
      send(0, 0, 1'b0);
      send(40, 41, 1'b1);
      clk_q.push_back(clampxy(40, 41));
      send(0, 0, 1'b0);
      send(42, 43, 1'b1);
      send(0, 0, 1'b0);
      vectors++;
      if (mif.click_ovf !== 1'b1) begin
         errors++;
         $display("FAIL b2b_ovf got %b want 1", mif.click_ovf);
      end
      mif.click_ready = 1'b1;
      e = clk_q.pop_front();
      vectors++;
      if (mif.click_x !== e.x || mif.click_y !== e.y) begin
         errors++;
         $display("FAIL b2b_first got %0d,%0d want %0d,%0d",
                  mif.click_x, mif.click_y, e.x, e.y);
      end
      send(44, 45, 1'b1);
      clk_q.push_back(clampxy(44, 45));
      e = clk_q.pop_front();
      vectors++;
      if ({mif.click_valid, mif.click_ovf} !== 2'b10 ||
          mif.click_x !== e.x || mif.click_y !== e.y) begin
         errors++;
         $display("FAIL b2b_reload got v=%b o=%b %0d,%0d want 1,0 %0d,%0d",
                  mif.click_valid, mif.click_ovf,
                  mif.click_x, mif.click_y, e.x, e.y);
      end
      step();
      mif.click_ready = 1'b0;
      vectors++;
      if (mif.click_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drain got v=%b want 0", mif.click_valid);
      end
   endtask

   task automatic test_reset_click();
      send(0, 0, 1'b0);
      send(9, 9, 1'b1);
      vectors++;
      if (mif.click_valid !== 1'b1) begin
         errors++;
         $display("FAIL rclick_set got v=%b want 1", mif.click_valid);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      vectors++;
      if (mif.click_valid !== 1'b0 || mif.click_x !== 12'd0) begin
         errors++;
         $display("FAIL rclick_drop got v=%b x=%0d want 0,0",
                  mif.click_valid, mif.click_x);
      end
      vectors++;
      if (pos_q.size() != 0) begin
         errors++;
         $display("FAIL pos_queue got %0d left want 0", pos_q.size());
      end
   endtask

   initial begin
      mif.xpos_raw    = '0;
      mif.ypos_raw    = '0;
      mif.left_raw    = 1'b0;
      mif.new_event   = 1'b0;
      mif.vblnk       = 1'b0;
      mif.click_ready = 1'b0;
      test_reset();
      test_commit();
      test_bypass();
      test_clamp();
      test_idle_vb();
      test_reset_pending();
      test_click_ovf();
      test_held();
      test_back_to_back();
      test_reset_click();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
